// File: rtl/dcache_mshr_ctrl.sv
// dcache_mshr_ctrl
//   Miss status holding register controller for a blocking-free data cache.
//   Incoming read misses are merged into an outstanding entry with the same
//   block tag or allocated into the lowest free entry. One block repair
//   request at a time is presented to an external arbiter. Returning fills
//   complete the matching issued entry and produce a one-cycle response.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   miss_valid/addr/ready/id     miss intake; ready and id are combinational
//   repair_req_valid/addr/ready  registered repair request, held until ready
//   fill_valid/addr/data         returned block data
//   resp_valid/id/data/merge_cnt one-cycle completion pulse with entry info
//   err_unexpected_fill          one-cycle pulse for a fill with no issued match
module dcache_mshr_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int BLOCK_W  = 256,
  parameter int NUM_MSHR = 4,
  localparam int OFF_W   = $clog2(BLOCK_W / 8),
  localparam int ID_W    = $clog2(NUM_MSHR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  input  logic [ADDR_W-1:0]  miss_addr,
  output logic               miss_ready,
  output logic [ID_W-1:0]    miss_id,
  output logic               repair_req_valid,
  output logic [ADDR_W-1:0]  repair_req_addr,
  input  logic               repair_req_ready,
  input  logic               fill_valid,
  input  logic [ADDR_W-1:0]  fill_addr,
  input  logic [BLOCK_W-1:0] fill_data,
  output logic               resp_valid,
  output logic [ID_W-1:0]    resp_id,
  output logic [BLOCK_W-1:0] resp_data,
  output logic [3:0]         resp_merge_cnt,
  output logic               err_unexpected_fill
);

  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2
  } entry_state_t;

  entry_state_t     state_reg [NUM_MSHR];
  logic [TAG_W-1:0] tag_reg   [NUM_MSHR];
  logic [3:0]       cnt_reg   [NUM_MSHR];

  logic              req_valid_reg;
  logic [ID_W-1:0]   req_idx_reg;
  logic [ADDR_W-1:0] req_addr_reg;

  logic               resp_valid_reg;
  logic [ID_W-1:0]    resp_id_reg;
  logic [BLOCK_W-1:0] resp_data_reg;
  logic [3:0]         resp_cnt_reg;
  logic               err_reg;

  logic [TAG_W-1:0] miss_tag;
  logic [TAG_W-1:0] fill_tag;
  assign miss_tag = miss_addr[ADDR_W-1:OFF_W];
  assign fill_tag = fill_addr[ADDR_W-1:OFF_W];

  // Per-entry match vectors.
  logic [NUM_MSHR-1:0] hit_vec;
  logic [NUM_MSHR-1:0] free_vec;
  logic [NUM_MSHR-1:0] pend_vec;
  logic [NUM_MSHR-1:0] fill_vec;

  for (genvar gi = 0; gi < NUM_MSHR; gi++) begin : g_match
    assign hit_vec[gi]  = (state_reg[gi] != ST_INVALID) && (tag_reg[gi] == miss_tag);
    assign free_vec[gi] = (state_reg[gi] == ST_INVALID);
    assign pend_vec[gi] = (state_reg[gi] == ST_PENDING);
    assign fill_vec[gi] = (state_reg[gi] == ST_ISSUED) && (tag_reg[gi] == fill_tag);
  end

  // Lowest-index encoders. Tags are unique among valid entries, so hit_vec
  // and fill_vec are at most one-hot.
  logic [ID_W-1:0] hit_idx, free_idx, pend_idx, fill_idx;

  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    pend_idx = '0;
    fill_idx = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (hit_vec[i])  hit_idx  = ID_W'(i);
      if (free_vec[i]) free_idx = ID_W'(i);
      if (pend_vec[i]) pend_idx = ID_W'(i);
      if (fill_vec[i]) fill_idx = ID_W'(i);
    end
  end

  logic hit, free_any, pend_any, fill_hit;
  logic hit_sat, fill_collide;
  logic accept, alloc_en, merge_en, handshake;

  assign hit      = |hit_vec;
  assign free_any = |free_vec;
  assign pend_any = |pend_vec;
  assign fill_hit = fill_valid && (|fill_vec);

  assign hit_sat = hit && (cnt_reg[hit_idx] == 4'hF);
  // A miss to a block whose fill is arriving this cycle is held off so it
  // never merges into an entry that is being freed.
  assign fill_collide = fill_valid && (fill_tag == miss_tag);

  assign miss_ready = !fill_collide && (hit ? !hit_sat : free_any);
  assign miss_id    = hit ? hit_idx : free_idx;

  assign accept    = miss_valid && miss_ready;
  assign alloc_en  = accept && !hit;
  assign merge_en  = accept && hit;
  assign handshake = req_valid_reg && repair_req_ready;

  // Issue selection: the oldest-index pending entry wins; when nothing is
  // pending, a miss being allocated this cycle is issued directly so its
  // request appears on the very next cycle.
  logic             issue_load;
  logic [ID_W-1:0]  issue_idx;
  logic [TAG_W-1:0] issue_tag;

  assign issue_load = !req_valid_reg && (pend_any || alloc_en);
  assign issue_idx  = pend_any ? pend_idx : free_idx;
  assign issue_tag  = pend_any ? tag_reg[pend_idx] : miss_tag;

  // Entry state. Allocation, merge, handshake and fill touch disjoint
  // entries or disjoint fields, so they are applied independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_reg[i] <= ST_INVALID;
        tag_reg[i]   <= '0;
        cnt_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (alloc_en && (free_idx == ID_W'(i))) begin
          state_reg[i] <= ST_PENDING;
          tag_reg[i]   <= miss_tag;
          cnt_reg[i]   <= '0;
        end else if (merge_en && (hit_idx == ID_W'(i))) begin
          cnt_reg[i] <= cnt_reg[i] + 4'd1;
        end
        if (handshake && (req_idx_reg == ID_W'(i))) begin
          state_reg[i] <= ST_ISSUED;
        end
        if (fill_hit && (fill_idx == ID_W'(i))) begin
          state_reg[i] <= ST_INVALID;
        end
      end
    end
  end

  // Repair request register: loaded only while idle, held until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_reg <= 1'b0;
      req_idx_reg   <= '0;
      req_addr_reg  <= '0;
    end else if (req_valid_reg) begin
      if (repair_req_ready) begin
        req_valid_reg <= 1'b0;
      end
    end else if (issue_load) begin
      req_valid_reg <= 1'b1;
      req_idx_reg   <= issue_idx;
      req_addr_reg  <= {issue_tag, {OFF_W{1'b0}}};
    end
  end

  // Completion and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_data_reg  <= '0;
      resp_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      resp_valid_reg <= fill_hit;
      err_reg        <= fill_valid && !fill_hit;
      if (fill_hit) begin
        resp_id_reg   <= fill_idx;
        resp_data_reg <= fill_data;
        resp_cnt_reg  <= cnt_reg[fill_idx];
      end
    end
  end

  assign repair_req_valid    = req_valid_reg;
  assign repair_req_addr     = req_addr_reg;
  assign resp_valid          = resp_valid_reg;
  assign resp_id             = resp_id_reg;
  assign resp_data           = resp_data_reg;
  assign resp_merge_cnt      = resp_cnt_reg;
  assign err_unexpected_fill = err_reg;

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed testbench for dcache_mshr_ctrl with default parameters
// (ADDR_W=32, BLOCK_W=256, NUM_MSHR=4). Inputs change 1 ns after the rising
// edge; combinational outputs are checked 1 ns after an input change and
// registered outputs 1 ns after the edge.
module tb_dcache_mshr_ctrl;

  localparam int ADDR_W   = 32;
  localparam int BLOCK_W  = 256;
  localparam int NUM_MSHR = 4;
  localparam int ID_W     = 2;

  logic               clk;
  logic               rst;
  logic               miss_valid;
  logic [ADDR_W-1:0]  miss_addr;
  logic               miss_ready;
  logic [ID_W-1:0]    miss_id;
  logic               repair_req_valid;
  logic [ADDR_W-1:0]  repair_req_addr;
  logic               repair_req_ready;
  logic               fill_valid;
  logic [ADDR_W-1:0]  fill_addr;
  logic [BLOCK_W-1:0] fill_data;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [BLOCK_W-1:0] resp_data;
  logic [3:0]         resp_merge_cnt;
  logic               err_unexpected_fill;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_mshr_ctrl #(
    .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .NUM_MSHR(NUM_MSHR)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .miss_id(miss_id),
    .repair_req_valid(repair_req_valid), .repair_req_addr(repair_req_addr),
    .repair_req_ready(repair_req_ready),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_merge_cnt(resp_merge_cnt),
    .err_unexpected_fill(err_unexpected_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs,
                     input logic [BLOCK_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [BLOCK_W-1:0] data_a;
  logic [BLOCK_W-1:0] data_b;

  initial begin
    data_a = {32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
              32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    data_b = {8{32'hC0FF_EE00}};
    rst = 1'b0;
    miss_valid = 1'b0; miss_addr = '0;
    repair_req_ready = 1'b0;
    fill_valid = 1'b0; fill_addr = '0; fill_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_req_valid", repair_req_valid, 0);
    chk("rst_req_addr", repair_req_addr, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_err", err_unexpected_fill, 0);
    rst = 1'b1;
    tick();

    // Single miss, issue, fill
    miss_valid = 1'b1; miss_addr = 32'hAABB_CCDD;
    #1;
    chk("single_ready", miss_ready, 1);
    chk("single_id", miss_id, 0);
    tick();
    miss_valid = 1'b0;
    chk("single_req_valid", repair_req_valid, 1);
    chk("single_req_addr", repair_req_addr, 32'hAABB_CCC0);
    repair_req_ready = 1'b1;
    tick();
    repair_req_ready = 1'b0;
    chk("single_req_drop", repair_req_valid, 0);
    fill_valid = 1'b1; fill_addr = 32'hAABB_CCC0; fill_data = data_a;
    tick();
    fill_valid = 1'b0;
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_id", resp_id, 0);
    chk("single_resp_cnt", resp_merge_cnt, 0);
    chk("single_resp_data", resp_data, data_a);
    chk("single_err", err_unexpected_fill, 0);
    tick();
    chk("single_resp_pulse", resp_valid, 0);

    // Merge: three misses in one block, one request
    miss_valid = 1'b1; miss_addr = 32'h0000_1000;
    #1; chk("merge0_id", miss_id, 0);
    tick();
    miss_addr = 32'h0000_1004;
    #1; chk("merge1_ready", miss_ready, 1); chk("merge1_id", miss_id, 0);
    tick();
    miss_addr = 32'h0000_101C;
    #1; chk("merge2_ready", miss_ready, 1); chk("merge2_id", miss_id, 0);
    tick();
    miss_valid = 1'b0;
    chk("merge_req_addr", repair_req_addr, 32'h0000_1000);
    repair_req_ready = 1'b1;
    tick();
    repair_req_ready = 1'b0;
    chk("merge_req_drop", repair_req_valid, 0);
    tick();
    chk("merge_single_req", repair_req_valid, 0);
    fill_valid = 1'b1; fill_addr = 32'h0000_1000; fill_data = data_b;
    tick();
    fill_valid = 1'b0;
    chk("merge_resp_valid", resp_valid, 1);
    chk("merge_resp_cnt", resp_merge_cnt, 2);
    chk("merge_resp_data", resp_data, data_b);

    // Full: four blocks allocated, backpressure on the first request
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = 32'(i * 32'h100);
      #1;
      chk($sformatf("full_alloc%0d_ready", i), miss_ready, 1);
      chk($sformatf("full_alloc%0d_id", i), miss_id, i);
      tick();
    end
    miss_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), repair_req_valid, 1);
      chk($sformatf("bp%0d_addr", i), repair_req_addr, 32'h0000_0000);
      tick();
    end
    miss_valid = 1'b1; miss_addr = 32'h0000_0400;
    #1; chk("full_stall", miss_ready, 0);
    // Drain all four requests: handshake, idle, reload for each entry.
    repair_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    repair_req_ready = 1'b0;
    chk("full_all_issued", repair_req_valid, 0);
    chk("full_still_stall", miss_ready, 0);
    fill_valid = 1'b1; fill_addr = 32'h0000_0100; fill_data = data_a;
    #1; chk("full_free_not_same_cycle", miss_ready, 0);
    tick();
    fill_valid = 1'b0;
    chk("full_resp_valid", resp_valid, 1);
    chk("full_resp_id", resp_id, 1);
    #1;
    chk("full_realloc_ready", miss_ready, 1);
    chk("full_realloc_id", miss_id, 1);
    tick();
    miss_valid = 1'b0;
    chk("full_realloc_req", repair_req_valid, 1);
    chk("full_realloc_addr", repair_req_addr, 32'h0000_0400);

    // Fill to a PENDING-only entry is unexpected
    fill_valid = 1'b1; fill_addr = 32'h0000_0400;
    tick();
    fill_valid = 1'b0;
    chk("pend_fill_err", err_unexpected_fill, 1);
    chk("pend_fill_resp", resp_valid, 0);
    tick();
    chk("pend_fill_err_pulse", err_unexpected_fill, 0);
    chk("pend_fill_req_kept", repair_req_valid, 1);

    // Fill collision blocks a merge into the completing entry
    miss_valid = 1'b1; miss_addr = 32'h0000_0204;
    fill_valid = 1'b1; fill_addr = 32'h0000_0200; fill_data = data_b;
    #1; chk("collide_ready", miss_ready, 0);
    tick();
    miss_valid = 1'b0; fill_valid = 1'b0;
    chk("collide_resp_valid", resp_valid, 1);
    chk("collide_resp_id", resp_id, 2);
    chk("collide_resp_cnt", resp_merge_cnt, 0);

    // Reset discards outstanding entries; unexpected fills afterwards
    rst = 1'b0; tick(); rst = 1'b1; tick();
    fill_valid = 1'b1; fill_addr = 32'hDEAD_0000;
    tick();
    fill_valid = 1'b0;
    chk("unexp_err", err_unexpected_fill, 1);
    chk("unexp_resp", resp_valid, 0);
    tick();
    chk("unexp_err_pulse", err_unexpected_fill, 0);
    fill_valid = 1'b1; fill_addr = 32'h0000_0000;
    tick();
    fill_valid = 1'b0;
    chk("post_rst_fill_err", err_unexpected_fill, 1);
    tick();

    // Saturation: first miss allocates, 15 merges bring count to 15, next stalls
    miss_valid = 1'b1; miss_addr = 32'h0000_2000;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!miss_ready || miss_id !== 0) begin
        chk($sformatf("sat_accept%0d", i), {miss_ready, miss_id}, 3'b100);
      end
      tick();
    end
    chk("sat_stall", miss_ready, 0);
    chk("sat_req_valid", repair_req_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_req", repair_req_valid, 0);
    chk("async_rst_entries", {miss_ready, miss_id}, 3'b100);
    tick();
    rst = 1'b1;
    miss_valid = 1'b0;
    tick();
    fill_valid = 1'b1; fill_addr = 32'h0000_2000;
    tick();
    fill_valid = 1'b0;
    chk("sat_rst_fill_err", err_unexpected_fill, 1);
    chk("sat_rst_fill_resp", resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
